// File: rtl/slc3_trace_buffer_if.sv
// Bus bundle for slc3_trace_buffer: capture/readout controls in, popped entry and status out.
// master = controller side (drives capture and readout), slave = trace buffer.
interface slc3_trace_buffer_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned DW = CHANNELS * WIDTH;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          sample_en;
    logic [DW-1:0] ch_data;
    logic          freeze;
    logic          rd_req;
    logic [WIDTH-1:0] trig_value;

    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          wrapped;
    logic [1:0]    state;

    modport master (
        output sample_en, ch_data, freeze, rd_req, trig_value,
        input  rd_data, rd_valid, count, full, empty, wrapped, state
    );

    modport slave (
        input  sample_en, ch_data, freeze, rd_req, trig_value,
        output rd_data, rd_valid, count, full, empty, wrapped, state
    );
endinterface

// File: rtl/slc3_trace_buffer.sv
// Circular multi-channel trace buffer for the SLC-3 datapath: captures until frozen, then pops oldest-first.
// Optional `TRACE_TRIGGER_EN: capture starts only on a channel-0 match against trig_value.
module slc3_trace_buffer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CHANNELS = 4
) (
    input  logic               clk,
    input  logic               reset,
    slc3_trace_buffer_if.slave bus
);
    localparam int unsigned DW = CHANNELS * WIDTH;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("slc3_trace_buffer: DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        FROZEN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            wrapped_q;
    logic            rd_valid_q;
    logic [DW-1:0]   rd_data_q;
    logic [DW-1:0]   mem [DEPTH];

    logic            do_write;
    logic            do_read;
    logic            do_clear;
    logic            is_full;
    logic [WIDTH-1:0] ch0;

    assign ch0     = bus.ch_data[WIDTH-1:0];
    assign is_full = (count_q == CW'(DEPTH));

`ifndef TRACE_TRIGGER_EN
    // Trigger compare value is not consulted when capture arms unconditionally.
    logic unused_trig;
    assign unused_trig = ^{bus.trig_value, ch0};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d  = state_q;
        do_write = 1'b0;
        do_read  = 1'b0;
        do_clear = 1'b0;
        case (state_q)
            ARMED: begin
                if (bus.freeze) begin
                    state_d = FROZEN;
                end else begin
`ifdef TRACE_TRIGGER_EN
                    // Triggering sample becomes the first recorded entry.
                    if (bus.sample_en && (ch0 == bus.trig_value)) begin
                        do_write = 1'b1;
                        state_d  = CAPTURE;
                    end
`else
                    state_d = CAPTURE;
`endif
                end
            end
            CAPTURE: begin
                // A sample coinciding with freeze is still recorded.
                do_write = bus.sample_en;
                if (bus.freeze) begin
                    state_d = FROZEN;
                end
            end
            FROZEN: begin
                if (!bus.freeze) begin
                    do_clear = 1'b1;
                    state_d  = ARMED;
                end else if (bus.rd_req && (count_q != '0)) begin
                    do_read = 1'b1;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    // Pointers, occupancy and readout register
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= do_read;
            if (do_clear) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                count_q   <= '0;
                wrapped_q <= 1'b0;
            end else if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                if (is_full) begin
                    // Overwrite drops the oldest entry.
                    rd_ptr_q  <= rd_ptr_q + PW'(1);
                    wrapped_q <= 1'b1;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end else if (do_read) begin
                rd_data_q <= mem[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                count_q   <= count_q - CW'(1);
            end
        end
    end

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (reset && do_write) begin
            mem[wr_ptr_q] <= bus.ch_data;
        end
    end

    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.wrapped  = wrapped_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.full     = is_full;
    assign bus.empty    = (count_q == '0);

endmodule

// File: tb/tb_slc3_trace_buffer.sv
// Self-checking bench for slc3_trace_buffer (DEPTH=4); scoreboard queue models the circular buffer.
module tb_slc3_trace_buffer;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned DW       = CHANNELS * WIDTH;
`ifdef TRACE_TRIGGER_EN
    localparam bit TRIG = 1'b1;
`else
    localparam bit TRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    slc3_trace_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) bus ();

    slc3_trace_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_last;
    bit          exp_cap;
    bit          exp_wrapped;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk(input logic [15:0] v);
        return {v ^ 16'hC000, v ^ 16'h8000, v ^ 16'h4000, v};
    endfunction

    task automatic chk_status(input string tag);
        chk({tag, " count"},   64'(bus.count),   64'(sb.size()));
        chk({tag, " full"},    64'(bus.full),    64'(sb.size() == DEPTH));
        chk({tag, " empty"},   64'(bus.empty),   64'(sb.size() == 0));
        chk({tag, " wrapped"}, 64'(bus.wrapped), 64'(exp_wrapped));
    endtask

    task automatic sample(input logic [15:0] v, input bit frz);
        if (TRIG && !exp_cap && !frz && v == bus.trig_value) exp_cap = 1'b1;
        if (exp_cap) begin
            sb.push_back(mk(v));
            if (sb.size() > DEPTH) begin
                void'(sb.pop_front());
                exp_wrapped = 1'b1;
            end
        end
        bus.sample_en = 1'b1;
        bus.ch_data   = mk(v);
        bus.freeze    = frz;
        cycle();
        bus.sample_en = 1'b0;
        if (frz) begin
            exp_cap = 1'b0;
            chk("frz_sample state", 64'(bus.state), 64'd2);
        end
        chk_status("sample");
    endtask

    task automatic freeze_now();
        bus.freeze    = 1'b1;
        bus.sample_en = 1'b0;
        cycle();
        exp_cap = 1'b0;
        chk("freeze state", 64'(bus.state), 64'd2);
        chk_status("freeze");
    endtask

    task automatic pop(input string tag);
        bit ev;
        ev = (sb.size() > 0);
        bus.rd_req = 1'b1;
        cycle();
        chk({tag, " valid"}, 64'(bus.rd_valid), 64'(ev));
        if (ev) exp_last = sb.pop_front();
        chk({tag, " data"}, 64'(bus.rd_data), 64'(exp_last));
        chk_status(tag);
    endtask

    task automatic rearm();
        bus.freeze = 1'b0;
        bus.rd_req = 1'b1;
        cycle();
        bus.rd_req = 1'b0;
        sb.delete();
        exp_wrapped = 1'b0;
        chk("rearm state", 64'(bus.state), 64'd0);
        chk("rearm valid", 64'(bus.rd_valid), 64'd0);
        chk_status("rearm");
        if (!TRIG) begin
            cycle();
            chk("rearm capture", 64'(bus.state), 64'd1);
            exp_cap = 1'b1;
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus.sample_en  = 1'b0;
        bus.ch_data    = '0;
        bus.freeze     = 1'b0;
        bus.rd_req     = 1'b0;
        bus.trig_value = '0;
        exp_last       = '0;
        exp_wrapped    = 1'b0;
        exp_cap        = 1'b0;
        cycle();
        cycle();
        chk("reset state", 64'(bus.state), 64'd0);
        chk("reset valid", 64'(bus.rd_valid), 64'd0);
        chk("reset data", 64'(bus.rd_data), 64'd0);
        chk_status("reset");

        reset = 1'b1;
        cycle();
        chk("post reset state", 64'(bus.state), TRIG ? 64'd0 : 64'd1);
        exp_cap = !TRIG;

        // In-order readout, back-to-back pops, hold after last pop
        bus.trig_value = 16'h3000;
        for (int i = 0; i < 3; i++) sample(16'(16'h3000 + i), 1'b0);
        freeze_now();
        for (int i = 0; i < 3; i++) pop("basic");
        bus.rd_req = 1'b0;
        cycle();
        chk("hold valid", 64'(bus.rd_valid), 64'd0);
        chk("hold data", 64'(bus.rd_data), 64'(exp_last));
        rearm();

        // Read request outside FROZEN is ignored
        bus.trig_value = 16'h0001;
        bus.rd_req = 1'b1;
        cycle();
        bus.rd_req = 1'b0;
        chk("rd outside frozen valid", 64'(bus.rd_valid), 64'd0);
        chk_status("rd outside frozen");

        // Overflow wraps and drops oldest
        for (int i = 1; i <= 6; i++) sample(16'(i), 1'b0);
        freeze_now();
        for (int i = 0; i < 5; i++) pop("wrap");
        bus.rd_req = 1'b0;
        rearm();

        // Trigger-qualified start (plain start when trigger is compiled out)
        bus.trig_value = 16'h0031;
        sample(16'h0010, 1'b0);
        sample(16'h0031, 1'b0);
        sample(16'h0032, 1'b0);
        freeze_now();
        for (int i = 0; i < 4; i++) pop("trig");
        bus.rd_req = 1'b0;
        rearm();

        // Sample coincident with freeze is kept; later samples ignored
        bus.trig_value = 16'h0100;
        sample(16'h0100, 1'b0);
        sample(16'hBEEF, 1'b1);
        bus.sample_en = 1'b1;
        bus.ch_data   = mk(16'h1111);
        cycle();
        bus.sample_en = 1'b0;
        chk_status("frozen ignore");
        for (int i = 0; i < 3; i++) pop("beef");
        bus.rd_req = 1'b0;
        rearm();

        // Reset mid-readout
        bus.trig_value = 16'h0500;
        for (int i = 0; i < 3; i++) sample(16'(16'h0500 + i), 1'b0);
        freeze_now();
        pop("pre reset");
        reset = 1'b0;
        bus.rd_req = 1'b1;
        cycle();
        sb.delete();
        exp_last    = '0;
        exp_wrapped = 1'b0;
        chk("midread reset state", 64'(bus.state), 64'd0);
        chk("midread reset valid", 64'(bus.rd_valid), 64'd0);
        chk("midread reset data", 64'(bus.rd_data), 64'd0);
        chk_status("midread reset");
        bus.rd_req = 1'b0;
        bus.freeze = 1'b0;
        reset      = 1'b1;
        cycle();
        chk("re-release state", 64'(bus.state), TRIG ? 64'd0 : 64'd1);
        exp_cap = !TRIG;

        // Dropping freeze with entries held clears everything
        bus.trig_value = 16'h0700;
        for (int i = 0; i < 3; i++) sample(16'(16'h0700 + i), 1'b0);
        freeze_now();
        rearm();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
